// File: rtl/axerr_monitor.sv
// Error-metric collector: accumulates error distance, error count and sample
// count between paired approximate/exact sums. Max tracking is built only when AXERR_MAX_EN is defined.
module axerr_monitor #(
  parameter int N     = 32,
  parameter int CNT_W = 16,
  parameter int ACC_W = 48
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [N-1:0]     apx_s_i,
  input  logic             apx_c_i,
  input  logic [N-1:0]     exa_s_i,
  input  logic             exa_c_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ACC_W-1:0] sum_ed_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] smp_cnt_o,
  output logic [N:0]       max_ed_o
);

  localparam int EW = N + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] smp_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;
  logic [ACC_W-1:0] sum_ed_reg;
  logic             s1_valid_reg;
  logic [EW-1:0]    s1_ed_reg;
  logic             s1_nz_reg;

  logic [EW-1:0]    exa_v, apx_v, ed;
  logic             accept, start_take, last_acc;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_sat;

  assign exa_v = {exa_c_i, exa_s_i};
  assign apx_v = {apx_c_i, apx_s_i};
  assign ed    = (exa_v >= apx_v) ? (exa_v - apx_v) : (apx_v - exa_v);

  assign ready_o    = (state_reg == RUN);
  assign busy_o     = (state_reg == RUN) || (state_reg == DRAIN);
  assign done_o     = (state_reg == DONE);
  assign accept     = valid_i && ready_o;
  assign start_take = (state_reg == IDLE) && start_i;
  assign last_acc   = accept && ((smp_cnt_reg + CNT_W'(1)) == len_reg);

  // One guard bit catches the carry so the accumulator clamps instead of wrapping
  assign sum_wide = {1'b0, sum_ed_reg} + (ACC_W+1)'(s1_ed_reg);
  assign sum_sat  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i) state_next = (len_i != '0) ? RUN : DONE;
      RUN:     if (last_acc) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      smp_cnt_reg  <= '0;
      err_cnt_reg  <= '0;
      sum_ed_reg   <= '0;
      s1_valid_reg <= 1'b0;
      s1_ed_reg    <= '0;
      s1_nz_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      s1_valid_reg <= accept;
      if (accept) begin
        s1_ed_reg   <= ed;
        s1_nz_reg   <= (ed != '0);
        smp_cnt_reg <= smp_cnt_reg + CNT_W'(1);
      end
      if (start_take) begin
        len_reg      <= len_i;
        smp_cnt_reg  <= '0;
        err_cnt_reg  <= '0;
        sum_ed_reg   <= '0;
        s1_valid_reg <= 1'b0;
      end else if (s1_valid_reg) begin
        sum_ed_reg  <= sum_sat;
        err_cnt_reg <= err_cnt_reg + {{(CNT_W-1){1'b0}}, s1_nz_reg};
      end
    end
  end

  assign sum_ed_o  = sum_ed_reg;
  assign err_cnt_o = err_cnt_reg;
  assign smp_cnt_o = smp_cnt_reg;

`ifdef AXERR_MAX_EN
  logic [EW-1:0] max_ed_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_ed_reg <= '0;
    end else if (start_take) begin
      max_ed_reg <= '0;
    end else if (s1_valid_reg && (s1_ed_reg > max_ed_reg)) begin
      max_ed_reg <= s1_ed_reg;
    end
  end

  assign max_ed_o = max_ed_reg;
`else
  assign max_ed_o = '0;
`endif

endmodule
